// File: rtl/rp_8bit_timer.sv
// 8-bit timer/counter peripheral on a small I/O bus: prescaled counting, CTC mode,
// overflow and compare-match interrupt flags with mask, write-1-to-clear and acknowledge.
module rp_8bit_timer #(
    parameter logic [5:0] BASE = 6'h08
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_wen,
    input  logic       io_ren,
    input  logic [5:0] io_adr,
    input  logic [7:0] io_wdt,
    input  logic [7:0] io_msk,
    output logic [7:0] io_rdt,
    output logic [1:0] irq_req,
    input  logic [1:0] irq_ack
);

    localparam logic [2:0] OFF_CTRL = 3'd0;
    localparam logic [2:0] OFF_TCNT = 3'd1;
    localparam logic [2:0] OFF_OCR  = 3'd2;
    localparam logic [2:0] OFF_IMSK = 3'd3;
    localparam logic [2:0] OFF_IFLG = 3'd4;

    logic [2:0] r_cs;
    logic       r_ctc;
    logic [7:0] r_tcnt;
    logic [7:0] r_ocr;
    logic [1:0] r_imsk;
    logic [1:0] r_iflg;
    logic [9:0] r_pre;
    logic [7:0] r_rdt;

    logic       w_hit;
    logic [2:0] w_off;
    logic       w_wr;
    logic       w_wr_ctrl;
    logic       w_wr_tcnt;
    logic       w_wr_ocr;
    logic       w_wr_imsk;
    logic       w_wr_iflg;
    logic [7:0] w_wbits;
    logic [7:0] w_ctrl_cur;
    logic [7:0] w_ctrl_new;
    logic [7:0] w_tcnt_new;
    logic [7:0] w_ocr_new;
    logic [7:0] w_imsk_new;
    logic       w_tick;
    logic       w_match;
    logic [7:0] w_tcnt_next;
    logic [9:0] w_pre_next;
    logic [1:0] w_flag_set;
    logic [1:0] w_flag_clr;
    logic [1:0] w_iflg_next;
    logic [7:0] w_rdt_next;

    function automatic logic [7:0] f_mask_wr(input logic [7:0] old_val,
                                             input logic [7:0] wdt,
                                             input logic [7:0] msk);
        return (wdt & msk) | (old_val & ~msk);
    endfunction

    assign w_hit      = (io_adr[5:3] == BASE[5:3]);
    assign w_off      = io_adr[2:0];
    assign w_wr       = io_wen & w_hit;
    assign w_wr_ctrl  = w_wr & (w_off == OFF_CTRL);
    assign w_wr_tcnt  = w_wr & (w_off == OFF_TCNT);
    assign w_wr_ocr   = w_wr & (w_off == OFF_OCR);
    assign w_wr_imsk  = w_wr & (w_off == OFF_IMSK);
    assign w_wr_iflg  = w_wr & (w_off == OFF_IFLG);
    assign w_wbits    = io_wdt & io_msk;

    assign w_ctrl_cur = {4'b0000, r_ctc, r_cs};
    assign w_ctrl_new = f_mask_wr(w_ctrl_cur, io_wdt, io_msk);
    assign w_tcnt_new = f_mask_wr(r_tcnt, io_wdt, io_msk);
    assign w_ocr_new  = f_mask_wr(r_ocr, io_wdt, io_msk);
    assign w_imsk_new = f_mask_wr({6'b000000, r_imsk}, io_wdt, io_msk);

    // Prescaler runs only while a clock source is selected; any CTRL write restarts it.
    assign w_pre_next = (w_wr_ctrl || (r_cs == 3'd0)) ? 10'd0 : r_pre + 10'd1;

    always_comb begin
        w_tick = 1'b0;
        case (r_cs)
            3'd1:    w_tick = 1'b1;
            3'd2:    w_tick = (r_pre[2:0] == 3'h7);
            3'd3:    w_tick = (r_pre[5:0] == 6'h3F);
            3'd4:    w_tick = (r_pre[7:0] == 8'hFF);
            3'd5:    w_tick = (r_pre[9:0] == 10'h3FF);
            default: w_tick = 1'b0;
        endcase
    end

    assign w_match = (r_tcnt == r_ocr);

    // A software TCNT write overrides the tick entirely, including its flag updates.
    always_comb begin
        w_tcnt_next = r_tcnt;
        w_flag_set  = 2'b00;
        if (w_wr_tcnt) begin
            w_tcnt_next = w_tcnt_new;
        end else if (w_tick) begin
            if (r_ctc && w_match) begin
                w_tcnt_next = 8'h00;
            end else begin
                w_tcnt_next = r_tcnt + 8'd1;
            end
            w_flag_set[1] = w_match;
            w_flag_set[0] = (r_tcnt == 8'hFF) && (!r_ctc || (r_ocr == 8'hFF));
        end
    end

    assign w_flag_clr = (w_wr_iflg ? w_wbits[1:0] : 2'b00) | irq_ack;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_flag
            assign w_iflg_next[gi] = w_flag_set[gi] | (r_iflg[gi] & ~w_flag_clr[gi]);
        end
    endgenerate

    always_comb begin
        w_rdt_next = 8'h00;
        if (io_ren && w_hit) begin
            case (w_off)
                OFF_CTRL: w_rdt_next = w_ctrl_cur;
                OFF_TCNT: w_rdt_next = r_tcnt;
                OFF_OCR:  w_rdt_next = r_ocr;
                OFF_IMSK: w_rdt_next = {6'b000000, r_imsk};
                OFF_IFLG: w_rdt_next = {6'b000000, r_iflg};
                default:  w_rdt_next = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cs   <= 3'd0;
            r_ctc  <= 1'b0;
            r_tcnt <= 8'h00;
            r_ocr  <= 8'h00;
            r_imsk <= 2'b00;
            r_iflg <= 2'b00;
            r_pre  <= 10'd0;
            r_rdt  <= 8'h00;
        end else begin
            if (w_wr_ctrl) begin
                r_cs  <= w_ctrl_new[2:0];
                r_ctc <= w_ctrl_new[3];
            end
            if (w_wr_ocr) begin
                r_ocr <= w_ocr_new;
            end
            if (w_wr_imsk) begin
                r_imsk <= w_imsk_new[1:0];
            end
            r_tcnt <= w_tcnt_next;
            r_iflg <= w_iflg_next;
            r_pre  <= w_pre_next;
            r_rdt  <= w_rdt_next;
        end
    end

    assign io_rdt  = r_rdt;
    assign irq_req = r_iflg & r_imsk;

endmodule

// File: tb/tb_rp_8bit_timer.sv
// Randomized scoreboard bench for rp_8bit_timer: a behavioural model predicts io_rdt and
// irq_req for every cycle, a separate monitor pops and compares after each clock edge.
module tb_rp_8bit_timer;

    localparam logic [5:0] BASE = 6'h08;

    logic       clk;
    logic       rst;
    logic       io_wen;
    logic       io_ren;
    logic [5:0] io_adr;
    logic [7:0] io_wdt;
    logic [7:0] io_msk;
    logic [7:0] io_rdt;
    logic [1:0] irq_req;
    logic [1:0] irq_ack;

    rp_8bit_timer #(.BASE(BASE)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_wen  (io_wen),
        .io_ren  (io_ren),
        .io_adr  (io_adr),
        .io_wdt  (io_wdt),
        .io_msk  (io_msk),
        .io_rdt  (io_rdt),
        .irq_req (irq_req),
        .irq_ack (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rdt;
        logic [1:0] irq;
        bit         is_rd;
        int         adr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    // Behavioural model state (register contents as plain integers)
    int m_ctrl, m_tcnt, m_ocr, m_imsk, m_iflg, m_pre;

    function automatic int divisor(input int cs);
        case (cs)
            1: return 1;
            2: return 8;
            3: return 64;
            4: return 256;
            5: return 1024;
            default: return 0;
        endcase
    endfunction

    function automatic int mw(input int old_v, input int wdt, input int msk);
        return ((wdt & msk) | (old_v & ~msk)) & 255;
    endfunction

    // Advance the model one clock using the inputs currently applied; queue the outputs expected after the edge.
    task automatic model_step();
        exp_t e;
        int   off, cs, ctc, div, tick, hit, wr;
        int   n_tcnt, n_pre, set_f, clr_f;
        hit = (io_adr >> 3) == (BASE >> 3);
        off = io_adr & 7;
        wr  = io_wen && hit;
        cs  = m_ctrl & 7;
        ctc = (m_ctrl >> 3) & 1;
        div = divisor(cs);
        tick = (div != 0) && ((m_pre % div) == div - 1);
        e.rdt = 8'h00;
        e.is_rd = io_ren && hit && rst;
        e.adr = io_adr;
        if (!rst) begin
            m_ctrl = 0; m_tcnt = 0; m_ocr = 0; m_imsk = 0; m_iflg = 0; m_pre = 0;
        end else begin
            if (io_ren && hit) begin
                case (off)
                    0: e.rdt = 8'(m_ctrl);
                    1: e.rdt = 8'(m_tcnt);
                    2: e.rdt = 8'(m_ocr);
                    3: e.rdt = 8'(m_imsk);
                    4: e.rdt = 8'(m_iflg);
                    default: e.rdt = 8'h00;
                endcase
            end
            n_pre = ((wr && off == 0) || cs == 0) ? 0 : (m_pre + 1) % 1024;
            set_f = 0;
            n_tcnt = m_tcnt;
            if (wr && off == 1) begin
                n_tcnt = mw(m_tcnt, io_wdt, io_msk);
            end else if (tick) begin
                if (m_tcnt == m_ocr) set_f |= 2;
                if (ctc && m_tcnt == m_ocr) begin
                    n_tcnt = 0;
                    if (m_tcnt == 255) set_f |= 1;
                end else begin
                    n_tcnt = (m_tcnt + 1) % 256;
                    if (m_tcnt == 255 && !ctc) set_f |= 1;
                end
            end
            clr_f = irq_ack;
            if (wr && off == 4) clr_f |= (io_wdt & io_msk) & 3;
            m_iflg = set_f | (m_iflg & ~clr_f & 3);
            if (wr && off == 0) m_ctrl = mw(m_ctrl, io_wdt, io_msk) & 15;
            if (wr && off == 2) m_ocr  = mw(m_ocr, io_wdt, io_msk);
            if (wr && off == 3) m_imsk = mw(m_imsk, io_wdt, io_msk) & 3;
            m_tcnt = n_tcnt;
            m_pre  = n_pre;
        end
        e.irq = 2'(m_iflg & m_imsk);
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit rstn, input bit wen, input bit ren, input logic [5:0] adr,
                         input logic [7:0] wdt, input logic [7:0] msk, input logic [1:0] ack);
        @(negedge clk);
        rst = rstn; io_wen = wen; io_ren = ren; io_adr = adr;
        io_wdt = wdt; io_msk = msk; irq_ack = ack;
        model_step();
    endtask

    task automatic wr(input int off, input logic [7:0] val, input logic [7:0] msk);
        drive(1'b1, 1'b1, 1'b0, BASE | 6'(off), val, msk, 2'b00);
    endtask

    task automatic rd(input int off);
        drive(1'b1, 1'b0, 1'b1, BASE | 6'(off), 8'h00, 8'h00, 2'b00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, BASE, 8'h00, 8'h00, 2'b00);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, BASE, 8'h00, 8'h00, 2'b00);
    endtask

    // Monitor: one expected entry per clock, compared just after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (io_rdt !== e.rdt) begin
                n_errors++;
                $display("FAIL io_rdt cyc=%0d adr=%02h actual=%02h required=%02h", cyc, e.adr, io_rdt, e.rdt);
            end
            n_checks++;
            if (irq_req !== e.irq) begin
                n_errors++;
                $display("FAIL irq_req cyc=%0d actual=%b required=%b", cyc, irq_req, e.irq);
            end
            if (e.is_rd)
                $display("rd cyc=%0d adr=%02h rdt=%02h irq=%b", cyc, e.adr, io_rdt, irq_req);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int r, off, cs;
        logic [7:0] val, msk;
        logic [5:0] adr;
        logic [1:0] ack;
        logic [2:0] hi;
        rst = 1'b0; io_wen = 1'b0; io_ren = 1'b0; io_adr = 6'h00;
        io_wdt = 8'h00; io_msk = 8'h00; irq_ack = 2'b00;
        m_ctrl = 0; m_tcnt = 0; m_ocr = 0; m_imsk = 0; m_iflg = 0; m_pre = 0;

        // Reset state, all registers read back
        do_reset();
        for (int i = 0; i < 8; i++) rd(i);

        // Overflow from 0xFE with CS=1
        wr(3, 8'h01, 8'hFF); wr(2, 8'h00, 8'hFF); wr(1, 8'hFE, 8'hFF);
        wr(0, 8'h01, 8'hFF);
        idle(2); rd(1); rd(4);

        // CTC with /8, OCR=3, then acknowledge the compare interrupt
        do_reset();
        wr(3, 8'h02, 8'hFF); wr(2, 8'h03, 8'hFF); wr(0, 8'h0A, 8'hFF);
        for (int i = 0; i < 10; i++) begin idle(3); rd(1); end
        idle(3);
        drive(1'b1, 1'b0, 1'b0, BASE, 8'h00, 8'h00, 2'b10);
        idle(2); rd(4);

        // Masked CTRL write restarts the prescaler
        do_reset();
        wr(0, 8'h01, 8'hFF); idle(5);
        wr(0, 8'hFF, 8'h08); rd(0); idle(3); rd(1);

        // TCNT write coincident with a tick at 0xFF
        do_reset();
        wr(0, 8'h01, 8'hFF); wr(1, 8'hFF, 8'hFF); wr(1, 8'h10, 8'hFF);
        rd(1); rd(4);

        // IFLG clear in the same cycle as a compare match: set wins
        do_reset();
        wr(3, 8'h03, 8'hFF); wr(2, 8'h05, 8'hFF); wr(1, 8'hFE, 8'hFF);
        wr(0, 8'h01, 8'hFF); idle(2);
        wr(1, 8'h05, 8'hFF); wr(4, 8'h03, 8'hFF); rd(4);

        // Reserved offset, foreign address, reset mid-count
        rd(6);
        drive(1'b1, 1'b0, 1'b1, 6'h30, 8'h00, 8'h00, 2'b00);
        idle(3); do_reset();
        for (int i = 0; i < 5; i++) rd(i);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r   = $urandom_range(0, 99);
            off = $urandom_range(0, 7);
            hi  = BASE[5:3];
            if ($urandom_range(0, 9) == 0) hi = BASE[5:3] ^ 3'($urandom_range(1, 7));
            adr = {hi, 3'(off)};
            ack = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            val = 8'($urandom);
            msk = ($urandom_range(0, 9) < 7) ? 8'hFF : 8'($urandom);
            if (r < 1) begin
                do_reset();
            end else if (r < 12) begin
                if (off == 0) begin
                    case ($urandom_range(0, 7))
                        0: cs = 0; 1, 2, 3: cs = 1; 4, 5: cs = 2; 6: cs = 3; default: cs = 6;
                    endcase
                    val[2:0] = 3'(cs);
                end else if (off == 1 && $urandom_range(0, 2) == 0) begin
                    val = 8'hFC + 8'($urandom_range(0, 3));
                end
                drive(1'b1, 1'b1, 1'b0, adr, val, msk, ack);
            end else if (r < 45) begin
                drive(1'b1, 1'b0, 1'b1, adr, 8'h00, 8'h00, ack);
            end else begin
                drive(1'b1, 1'b0, 1'b0, adr, val, msk, ack);
            end
        end

        idle(1);
        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain actual=%0d entries required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rp_8bit_timer.md
RP_8BIT_TIMER -- requirements
Module: rp_8bit_timer

Interface
REQ-001 Parameter BASE, default 6'h08, is the I/O base address; BASE[2:0] shall be 0, i.e. the block occupies 8 consecutive I/O addresses.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low; sampled on posedge clk.
REQ-004 io_wen  input  1  I/O write enable from the core.
REQ-005 io_ren  input  1  I/O read enable from the core.
REQ-006 io_adr  input  6  I/O address.
REQ-007 io_wdt  input  8  I/O write data.
REQ-008 io_msk  input  8  I/O write bit mask; 1 = bit is written.
REQ-009 io_rdt  output  8  I/O read data, registered.
REQ-010 irq_req  output  2  interrupt requests to the core: [0] overflow, [1] compare match.
REQ-011 irq_ack  input  2  interrupt acknowledges from the core, same bit mapping as irq_req.

Function
REQ-012 Address hit: io_adr[5:3]==BASE[5:3]; offset = io_adr[2:0].
- 0 CTRL: [2:0] CS, [3] CTC, [7:4] read 0.
- 1 TCNT.
- 2 OCR.
- 3 IMSK: [0] OVE, [1] OCE, rest read 0.
- 4 IFLG: [0] TOV, [1] OCF, rest read 0.
- 5..7: reserved, read 0, writes ignored.
REQ-013 Write (io_wen & hit): reg <= io_wdt&io_msk | reg&~io_msk for CTRL, TCNT, OCR, IMSK; effective next cycle.
REQ-014 IFLG write is write-1-to-clear: a flag bit clears where io_wdt&io_msk is 1.
REQ-015 Read (io_ren & hit): io_rdt <= register value at offset, visible the cycle after io_ren; io_rdt shall be 8'h00 the cycle after any cycle without io_ren & hit, so it can be OR-combined with other peripherals.
REQ-016 Prescaler: 10-bit counter PRE, incremented every cycle while CS!=0; cleared when CS==0 and on any CTRL write.
REQ-017 Tick selection by CS:
- 0 = stopped, no ticks.
- 1 = every cycle.
- 2 = /8, tick when PRE[2:0]==7.
- 3 = /64, tick when PRE[5:0]==63.
- 4 = /256, tick when PRE[7:0]==255.
- 5 = /1024, tick when PRE[9:0]==1023.
- 6, 7 = stopped.
REQ-018 On tick with CTC=1 and TCNT==OCR: TCNT <= 0, OCF <= 1.
REQ-019 On tick otherwise: TCNT <= TCNT+1 modulo 256; OCF <= 1 if TCNT==OCR; TOV <= 1 if TCNT==8'hFF.
REQ-020 TOV shall never be set in CTC mode unless OCR==8'hFF.
REQ-021 A TCNT write in the same cycle as a tick: the written value wins; that tick's increment and flag setting are discarded.
REQ-022 Flag set has priority over a same-cycle clear from an IFLG write or irq_ack.
REQ-023 irq_ack[i]=1 clears the corresponding flag (TOV for [0], OCF for [1]).
REQ-024 irq_req[0] = TOV & OVE; irq_req[1] = OCF & OCE; both combinational from registers, no added latency.
REQ-025 OCR write takes effect for the compare on the next cycle; the compare uses the registered OCR.

Reset
REQ-026 With rst=0 at posedge clk, the following shall be 0 the next cycle: CTRL, TCNT, OCR, IMSK, IFLG, PRE, io_rdt, irq_req.
REQ-027 Reset overrides any concurrent io_wen, io_ren, tick or irq_ack; reset mid-count abandons the count with no flag set.

Verification
REQ-028 CS=1, OCR=0, CTC=0, TCNT=8'hFE, OVE=1 -> TOV and irq_req[0] rise 2 cycles after counting starts; TCNT=8'h00.
REQ-029 CS=2, CTC=1, OCR=3, OCE=1 -> OCF sets after 32 cycles; TCNT sequence 0,1,2,3,0; irq_req[1] stays 1 until irq_ack[1] pulse, then 0 the next cycle.
REQ-030 Masked write to CTRL with io_wdt=8'hFF, io_msk=8'h08 from CTRL=8'h01 -> CTRL reads 8'h09; PRE cleared.
REQ-031 TCNT write 8'h10 coincident with a tick at TCNT=8'hFF -> TCNT=8'h10, TOV stays 0.
REQ-032 IFLG write 8'h03 with the OCF set event in the same cycle -> TOV=0, OCF=1.
REQ-033 Read of offset 6 -> io_rdt=8'h00; read with io_adr outside BASE range -> io_rdt=8'h00; rst=0 during CS=1 counting -> all registers 0 next cycle.
